// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit bridging decode strobes to a single-outstanding req/gnt/rvalid bus
module dmem_lsu #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [2:0]        req_func3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [1:0]        resp_err,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t            state;
    logic [CW-1:0]     tmo_cnt;
    logic [1:0]        addr_lo;
    logic [2:0]        func3_q;
    logic              is_load;
    logic              gnt_q;
    logic              rvalid_q;
    logic [DWIDTH-1:0] rdata_q;

    logic              func3_ok;
    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_n;
    logic [DWIDTH-1:0] wdata_n;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DWIDTH-1:0] load_ext;
    logic              tmo_hit;

    assign stall   = req_valid & ~resp_valid;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_comb begin
        func3_ok = 1'b0;
        case (req_func3)
            3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
            3'b100, 3'b101:         func3_ok = ~req_wr;
            default:                func3_ok = 1'b0;
        endcase
        illegal    = (req_wr & req_rd) | ~func3_ok;
        misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        be_n    = 4'b1111;
        wdata_n = req_wdata;
        case (req_func3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{req_wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = req_wdata;
            end
        endcase
    end

    // Lane select uses the request's byte offset latched at accept time.
    always_comb begin
        lane_byte = rdata_q[7:0];
        case (addr_lo)
            2'd0: lane_byte = rdata_q[7:0];
            2'd1: lane_byte = rdata_q[15:8];
            2'd2: lane_byte = rdata_q[23:16];
            2'd3: lane_byte = rdata_q[31:24];
            default: lane_byte = rdata_q[7:0];
        endcase
        lane_half = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (func3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = rdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            addr_lo    <= 2'b00;
            func3_q    <= 3'b000;
            is_load    <= 1'b0;
            gnt_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 2'b00;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            // Bus responses are registered; the FSM acts on them one cycle later.
            gnt_q      <= mem_gnt & mem_req;
            rvalid_q   <= mem_rvalid;
            rdata_q    <= mem_rdata;
            case (state)
                IDLE: begin
                    if (req_valid && (req_wr || req_rd)) begin
                        if (illegal) begin
                            resp_err   <= 2'b11;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else if (misaligned) begin
                            resp_err   <= 2'b01;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            addr_lo   <= req_addr[1:0];
                            func3_q   <= req_func3;
                            is_load   <= ~req_wr;
                            mem_req   <= 1'b1;
                            mem_we    <= req_wr;
                            mem_be    <= be_n;
                            mem_addr  <= {req_addr[AWIDTH-1:2], 2'b00};
                            mem_wdata <= wdata_n;
                            tmo_cnt   <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (mem_req && mem_gnt) begin
                        mem_req <= 1'b0;
                    end
                    if (gnt_q) begin
                        if (is_load) begin
                            state <= WAIT_R;
                        end else begin
                            resp_err   <= 2'b00;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (tmo_hit) begin
                        mem_req    <= 1'b0;
                        resp_err   <= 2'b10;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WAIT_R: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (rvalid_q) begin
                        resp_rdata <= load_ext;
                        resp_err   <= 2'b00;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else if (tmo_hit) begin
                        resp_err   <= 2'b10;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a behavioural model
module tb_dmem_lsu;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic        req_rd;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_errors;

    dmem_lsu #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_rd     (req_rd),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic func3_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 <= 3'd2);
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_resp_err"},   32'(resp_err),   32'd0);
        check_eq({tag, "_resp_rdata"}, resp_rdata,      32'd0);
        check_eq({tag, "_mem_req"},    32'(mem_req),    32'd0);
        check_eq({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check_eq({tag, "_mem_be"},     32'(mem_be),     32'd0);
        check_eq({tag, "_mem_addr"},   mem_addr,        32'd0);
        check_eq({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    endtask

    // One request from presentation to completion. Cycle 0 presents the request;
    // the grant is driven in cycle 1+gd and read data rdly cycles after the cycle following it.
    task automatic do_txn(input logic wr, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rdly, input logic [31:0] bus_data);
        int g, r, need, lat, req_last, size;
        logic [1:0] exp_err;
        logic [3:0] exp_be;
        logic [31:0] exp_wd, exp_rd, lane8, lane16;
        logic bus;
        size = 1 << f3[1:0];
        if ((wr && ld) || !func3_legal(wr, f3)) exp_err = 2'b11;
        else if ((addr % size) != 0)            exp_err = 2'b01;
        else                                    exp_err = 2'b00;
        bus  = (exp_err == 2'b00);
        g    = 1 + gd;
        r    = g + 1 + rdly;
        need = ld ? r + 1 : g + 1;
        if (!bus) lat = 1;
        else if (need > TMO) begin lat = TMO + 1; exp_err = 2'b10; end
        else lat = need + 1;
        req_last = (g < TMO) ? g : TMO;
        case (f3[1:0])
            2'd0: begin exp_be = 4'(1 << addr[1:0]);       exp_wd = 32'(wd[7:0]) * 32'h01010101; end
            2'd1: begin exp_be = 4'(3 << (2 * addr[1]));   exp_wd = 32'(wd[15:0]) * 32'h00010001; end
            default: begin exp_be = 4'hF;                  exp_wd = wd; end
        endcase
        lane8  = (bus_data >> (8 * addr[1:0])) & 32'hFF;
        lane16 = (bus_data >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0:    exp_rd = (lane8 >= 32'd128) ? lane8 - 32'd256 : lane8;
            3'd1:    exp_rd = (lane16 >= 32'd32768) ? lane16 - 32'd65536 : lane16;
            3'd4:    exp_rd = lane8;
            3'd5:    exp_rd = lane16;
            default: exp_rd = bus_data;
        endcase

        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_rd     = ld;
        req_func3  = f3;
        req_addr   = addr;
        req_wdata  = wd;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            mem_gnt    = (k == g);
            mem_rvalid = ld && (k == r);
            mem_rdata  = (k == r) ? bus_data : $urandom;
            check_eq("stall",      32'(stall),      32'(k < lat));
            check_eq("resp_valid", 32'(resp_valid), 32'(k == lat));
            check_eq("mem_req",    32'(mem_req),    32'(bus && k <= req_last));
            if (bus && k == 1) begin
                check_eq("mem_addr", mem_addr,       addr & 32'hFFFFFFFC);
                check_eq("mem_be",   32'(mem_be),    32'(exp_be));
                check_eq("mem_we",   32'(mem_we),    32'(wr));
                if (wr) check_eq("mem_wdata", mem_wdata, exp_wd);
            end
        end
        check_eq("resp_err", 32'(resp_err), 32'(exp_err));
        if (ld && exp_err == 2'b00) check_eq("resp_rdata", resp_rdata, exp_rd);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle_stray(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            req_valid  = 1'b0;
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            check_eq("stray_resp_valid", 32'(resp_valid), 32'd0);
            check_eq("stray_mem_req",    32'(mem_req),    32'd0);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic        wr, ld;
        logic [31:0] a;
        int          sel;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_rd     = 1'b0;
        req_func3  = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_eq("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 32'd0);
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'd0, 0, 0, 32'h80FF_1234);
        do_txn(1'b0, 1'b1, 3'b100, 32'h0000_0203, 32'd0, 0, 0, 32'h80FF_1234);
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0000ABCD, 0, 0, 32'd0);
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'd0, 0, 0, 32'd0);
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'd0, 3, 1, 32'h1357_9BDF);
        do_txn(1'b0, 1'b1, 3'b101, 32'h0000_0402, 32'd0, 1, 0, 32'hF00D_8001);
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0402, 32'd0, 2, 1, 32'h8001_0000);

        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'd0, 50, 0, 32'd0);
        idle_stray(3);
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0504, 32'd0, 0, 0, 32'hCAFE_F00D);

        do_txn(1'b1, 1'b1, 3'b010, 32'h0000_0600, 32'h1111_2222, 0, 0, 32'd0);
        do_txn(1'b0, 1'b1, 3'b011, 32'h0000_0600, 32'd0, 0, 0, 32'd0);
        do_txn(1'b1, 1'b0, 3'b100, 32'h0000_0600, 32'h3333_4444, 0, 0, 32'd0);

        // Reset while a load waits for read data.
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b0; req_rd = 1'b1;
        req_func3 = 3'b010; req_addr = 32'h0000_0040;
        @(posedge clk); #1; mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0;
        @(posedge clk); #1; rst = 1'b1; #1;
        check_all_zero("mid_rst");
        req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_rvalid = (k == 0);
            check_eq("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        mem_rvalid = 1'b0;

        for (int i = 0; i < 60; i++) begin
            ld = 1'($urandom_range(0, 1));
            wr = ~ld;
            if ($urandom_range(0, 15) == 0) begin wr = 1'b1; ld = 1'b1; end
            sel = $urandom_range(0, 4);
            case (ld ? sel : sel % 3)
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            do_txn(wr, ld, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
